// File: rtl/rd_writeback_sequencer_pkg.sv
// Shared types for the rd write-back sequencer: rd source encoding, FSM states
// and the one-hot select lines that drive the rd input mux.
package rd_writeback_sequencer_pkg;

    typedef enum logic [2:0] {
        RD_NONE       = 3'd0,
        RD_MEMORY     = 3'd1,
        RD_ALU        = 3'd2,
        RD_IMMEDIATE  = 3'd3,
        RD_BRANCH_ALU = 3'd4
    } RDSource_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_MEM  = 2'd1,
        WRITEBACK = 2'd2
    } WritebackState_t;

    typedef struct packed {
        logic memoryOutputEnable;
        logic aluOutputEnable;
        logic immediateFormerOutputEnable;
        logic branchALUOutputEnable;
    } RDSourceSelectLines_t;

    localparam int unsigned TIMEOUT_COUNTER_W = 8;

    // Encodings 5..7 have no meaning and fold onto RD_NONE.
    function automatic RDSource_t decode_rd_source(input logic [2:0] raw);
        RDSource_t src;
        case (raw)
            3'd1, 3'd2, 3'd3, 3'd4: src = RDSource_t'(raw);
            default:                src = RD_NONE;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/rd_writeback_sequencer_select.sv
// Combinational rd source to rd-mux select-line encoder; NONE yields all zero.
module rd_select_encoder
    import rd_writeback_sequencer_pkg::*;
(
    input  RDSource_t            i_source,
    output RDSourceSelectLines_t o_select
);

    always_comb begin
        o_select = '0;
        case (i_source)
            RD_MEMORY:     o_select.memoryOutputEnable          = 1'b1;
            RD_ALU:        o_select.aluOutputEnable             = 1'b1;
            RD_IMMEDIATE:  o_select.immediateFormerOutputEnable = 1'b1;
            RD_BRANCH_ALU: o_select.branchALUOutputEnable       = 1'b1;
            default:       o_select = '0;
        endcase
    end

endmodule

// File: rtl/rd_writeback_sequencer.sv
// Register-file write-back sequencer: accepts one rd-writing op per handshake,
// waits for loads with a timeout, and issues a single-cycle write strobe.
module rd_writeback_sequencer
    import rd_writeback_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       opValid,
    output logic       opReady,
    input  logic [2:0] opRDSource,
    input  logic [4:0] opRDIndex,
    output logic       memReadRequest,
    input  logic       memReadDataValid,
    output logic [3:0] rdSourceSelectLines,
    output logic       rdWriteEnable,
    output logic [4:0] rdWriteIndex,
    output logic       memTimeoutError
);

    localparam logic [TIMEOUT_COUNTER_W-1:0] TIMEOUT_LAST = TIMEOUT_COUNTER_W'(MEM_TIMEOUT - 1);

    WritebackState_t               r_state;
    WritebackState_t               w_next_state;
    RDSource_t                     r_source;
    logic [4:0]                    r_index;
    logic [TIMEOUT_COUNTER_W-1:0]  r_count;
    logic                          r_mem_req;

    RDSourceSelectLines_t          r_sel;
    logic                          r_we;
    logic [4:0]                    r_widx;
    logic                          r_err;

    RDSourceSelectLines_t          w_encoded;
    RDSourceSelectLines_t          w_next_sel;
    logic                          w_next_we;
    logic [4:0]                    w_next_widx;
    logic                          w_next_err;

    RDSource_t                     w_op_source;
    logic                          w_transfer;
    logic                          w_timeout;

    assign w_op_source = decode_rd_source(opRDSource);
    assign opReady     = (r_state == IDLE);
    assign w_transfer  = opValid & opReady;
    // Data arriving in the last allowed cycle takes priority over the timeout.
    assign w_timeout   = (r_state == WAIT_MEM) && !memReadDataValid && (r_count == TIMEOUT_LAST);

    rd_select_encoder u_select_encoder (
        .i_source (r_source),
        .o_select (w_encoded)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_transfer) begin
                    case (w_op_source)
                        RD_MEMORY:                           w_next_state = WAIT_MEM;
                        RD_ALU, RD_IMMEDIATE, RD_BRANCH_ALU: w_next_state = WRITEBACK;
                        default:                             w_next_state = IDLE;
                    endcase
                end
            end
            WAIT_MEM: begin
                if (memReadDataValid) begin
                    w_next_state = WRITEBACK;
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            WRITEBACK: w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_next_sel  = '0;
        w_next_we   = 1'b0;
        w_next_widx = '0;
        w_next_err  = r_err | w_timeout;
        if (r_state == WRITEBACK) begin
            w_next_sel  = w_encoded;
            w_next_we   = (r_index != '0);
            w_next_widx = r_index;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_source  <= RD_NONE;
            r_index   <= '0;
            r_count   <= '0;
            r_mem_req <= 1'b0;
        end else begin
            r_mem_req <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_transfer && (w_op_source != RD_NONE)) begin
                        r_source  <= w_op_source;
                        r_index   <= opRDIndex;
                        r_count   <= '0;
                        r_mem_req <= (w_op_source == RD_MEMORY);
                    end
                end
                WAIT_MEM: begin
                    r_count <= r_count + 8'd1;
                    if (memReadDataValid) begin
                        r_source <= RD_MEMORY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sel  <= '0;
            r_we   <= 1'b0;
            r_widx <= '0;
            r_err  <= 1'b0;
        end else begin
            r_sel  <= w_next_sel;
            r_we   <= w_next_we;
            r_widx <= w_next_widx;
            r_err  <= w_next_err;
        end
    end

    // Masked by reset so an abandoned load never requests in the reset cycle.
    assign memReadRequest      = r_mem_req & ~reset;
    assign rdSourceSelectLines = r_sel;
    assign rdWriteEnable       = r_we;
    assign rdWriteIndex        = r_widx;
    assign memTimeoutError     = r_err;

endmodule
